// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine transaction sequencer.
// Latches the selection, checks stock, runs the coin-payment countdown,
// computes change and holds the result screens for the display block.
// Optional build macro VEND_CTRL_EXTEND_EN: a coin that does not complete
// payment reloads the countdown to TIMEOUT_S.
module vend_ctrl #(
  parameter int PRICE1    = 2,
  parameter int PRICE2    = 3,
  parameter int PRICE3    = 5,
  parameter int PRICE4    = 7,
  parameter int TIMEOUT_S = 30,
  parameter int HOLD_S    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       confirm,
  input  logic       cancel,
  input  logic       coin_valid,
  input  logic [7:0] coin_value,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic [3:0] num4,
  input  logic [3:0] stock1,
  input  logic [3:0] stock2,
  input  logic [3:0] stock3,
  input  logic [3:0] stock4,
  output logic [2:0] state,
  output logic [3:0] num_q1,
  output logic [3:0] num_q2,
  output logic [3:0] num_q3,
  output logic [3:0] num_q4,
  output logic [7:0] require_money,
  output logic [7:0] paid_money,
  output logic [7:0] left_time,
  output logic [7:0] change,
  output logic       not_enough,
  output logic       money_enough,
  output logic       done,
  output logic       dispense
);

  typedef enum logic [2:0] {
    S_ST     = 3'b001,
    S_SELECT = 3'b010,
    S_CHECK  = 3'b011,
    S_TIME   = 3'b100,
    S_PAY    = 3'b101,
    S_CHANGE = 3'b110,
    S_RETURN = 3'b111
  } state_t;

  state_t     st, st_nx;
  logic [3:0] hold_cnt;
  logic       chk_first;   // first cycle of CHECK: stock test is evaluated here
  logic [11:0] req_sum;
  logic [7:0]  req_sat;
  logic [8:0]  paid_sum;
  logic [7:0]  paid_nx;
  logic        short_f, hold_done, pay_ok, tmo, ext;

  assign state = st;

  // Total price at 12 bits, clipped to the 8-bit display range.
  assign req_sum = 12'(num1) * 12'(PRICE1) + 12'(num2) * 12'(PRICE2)
                 + 12'(num3) * 12'(PRICE3) + 12'(num4) * 12'(PRICE4);
  assign req_sat = (req_sum > 12'd255) ? 8'hFF : req_sum[7:0];

  // Paid total including a coin arriving this cycle, saturating at 255.
  assign paid_sum = {1'b0, paid_money} + (coin_valid ? {1'b0, coin_value} : 9'd0);
  assign paid_nx  = paid_sum[8] ? 8'hFF : paid_sum[7:0];
  assign pay_ok   = paid_nx >= require_money;

  // An empty selection is treated like a stock shortfall.
  assign short_f = (num_q1 > stock1) | (num_q2 > stock2) | (num_q3 > stock3)
                 | (num_q4 > stock4) | ({num_q1, num_q2, num_q3, num_q4} == 16'd0);

  // Hold exits on the HOLD_S-th tick after entry.
  assign hold_done = tick_1hz && (hold_cnt == 4'(HOLD_S - 1));

`ifdef VEND_CTRL_EXTEND_EN
  assign ext = coin_valid && !pay_ok;
`else
  assign ext = 1'b0;
`endif

  // A reloading coin keeps the countdown alive in the cycle it lands.
  assign tmo = !ext && (((left_time == 8'd1) && tick_1hz) || (left_time == 8'd0));

  // money_enough stays low while no price is latched (reset / idle).
  assign money_enough = (require_money != 8'd0) && (paid_money >= require_money);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st <= S_ST;
    else     st <= st_nx;
  end

  // Next-state decode.
  always_comb begin
    st_nx = st;
    case (st)
      S_ST:     if (start) st_nx = S_SELECT;
      S_SELECT: if (cancel) st_nx = S_ST;
                else if (confirm) st_nx = S_CHECK;
      S_CHECK:  if (chk_first) begin
                  if (!short_f) st_nx = S_TIME;
                end else if (hold_done) st_nx = S_ST;
      S_TIME:   if (cancel) st_nx = S_CHANGE;
                else if (pay_ok) st_nx = S_PAY;
                else if (tmo) st_nx = S_CHANGE;
      S_PAY:    st_nx = S_CHANGE;
      S_CHANGE: if (hold_done) st_nx = done ? S_RETURN : S_ST;
      S_RETURN: if (hold_done) st_nx = S_ST;
      default:  st_nx = S_ST;
    endcase
  end

  // Datapath registers: selection, money, countdown and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt      <= '0;
      chk_first     <= 1'b0;
      num_q1        <= '0;
      num_q2        <= '0;
      num_q3        <= '0;
      num_q4        <= '0;
      require_money <= '0;
      paid_money    <= '0;
      left_time     <= '0;
      change        <= '0;
      not_enough    <= 1'b0;
      done          <= 1'b0;
      dispense      <= 1'b0;
    end else begin
      dispense <= 1'b0;
      if ((st_nx != st) || ((st == S_CHECK) && chk_first)) hold_cnt <= '0;
      else if (tick_1hz)                                  hold_cnt <= hold_cnt + 4'd1;
      case (st)
        S_SELECT: if (!cancel && confirm) begin
          num_q1        <= num1;
          num_q2        <= num2;
          num_q3        <= num3;
          num_q4        <= num4;
          require_money <= req_sat;
          chk_first     <= 1'b1;
        end
        S_CHECK: if (chk_first) begin
          chk_first  <= 1'b0;
          not_enough <= short_f;
          if (!short_f) begin
            left_time  <= 8'(TIMEOUT_S);
            paid_money <= '0;
          end
        end else if (hold_done) begin
          not_enough <= 1'b0;
        end
        S_TIME: begin
          paid_money <= paid_nx;
          if (ext)                                left_time <= 8'(TIMEOUT_S);
          else if (tick_1hz && left_time != 8'd0) left_time <= left_time - 8'd1;
          if (cancel || (!pay_ok && tmo)) begin
            change <= paid_nx;
            done   <= 1'b0;
          end else if (pay_ok) begin
            dispense <= 1'b1;
            done     <= 1'b1;
            change   <= paid_nx - require_money;
          end
        end
        S_RETURN: if (hold_done) begin
          done       <= 1'b0;
          change     <= '0;
          paid_money <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
Transaction sequencer for the vending machine. It produces the paying-state code and all numeric values shown by the seven-segment display block: quantities, required money, paid money, countdown and change. It latches the customer selection, checks stock, runs a coin-payment countdown, computes change and holds result screens. It sits between the debounced button/coin inputs and the display/LED driver.

Parameters:
PRICE1, 2, price of item 1 (yuan, 8-bit)
PRICE2, 3, price of item 2
PRICE3, 5, price of item 3
PRICE4, 7, price of item 4
TIMEOUT_S, 30, payment countdown start value in seconds (1..99)
HOLD_S, 5, seconds each result screen (FAIL, change, done) is held (1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick_1hz  in  1  one-clk-wide enable pulse, once per second
start  in  1  one-cycle pulse, begin transaction
confirm  in  1  one-cycle pulse, accept selection
cancel  in  1  one-cycle pulse, abort
coin_valid  in  1  one-cycle pulse, coin inserted
coin_value  in  8  value of inserted coin (yuan)
num1..num4  in  4 each  requested quantity per item
stock1..stock4  in  4 each  available stock per item
state  out  3  001 ST, 010 SELECT, 011 CHECK, 100 TIME, 101 PAY, 110 CHANGE, 111 RETURN
num_q1..num_q4  out  4 each  latched quantities
require_money  out  8  total price
paid_money  out  8  accumulated coins
left_time  out  8  countdown seconds
change  out  8  money to return
not_enough  out  1  stock shortfall flag
money_enough  out  1  paid_money >= require_money
done  out  1  payment succeeded
dispense  out  1  one-cycle pulse, vend latched quantities

Behaviour:
- Reset (rst=1 at posedge clk, any state): state=ST. All counters, num_q*, require_money, paid_money, left_time, change, not_enough, money_enough, done and dispense are 0. Reset mid-transaction discards any coins; no refund is indicated.
- ST: on start, go to SELECT. All other inputs are ignored.
- SELECT: on confirm, latch num_q*=num*. require_money = sum(num_i*PRICE_i), computed at 12 bits and saturated to 255; it is registered in the same edge. Go to CHECK. On cancel, go to ST. If confirm and cancel arrive together, cancel wins.
- CHECK: in the first cycle, not_enough is registered as OR(num_q_i > stock_i), or all num_q_i = 0.
  - Pass: next cycle go to TIME, with left_time=TIMEOUT_S and paid_money=0.
  - Fail: stay in CHECK for HOLD_S ticks (display shows FAIL), then go to ST and clear not_enough.
- TIME:
  - coin_valid: paid_money += coin_value, saturating at 255.
  - tick_1hz: left_time -= 1, never below 0.
  - money_enough is combinational: paid_money >= require_money.
  - Exit evaluation each cycle, in priority order:
    1. cancel: go to CHANGE with change = paid_money (including any same-cycle coin), done=0.
    2. Paid total including the same-cycle coin >= require_money: go to PAY.
    3. left_time==1 and tick_1hz, or left_time==0: go to CHANGE with change=paid_money, done=0 (timeout refund).
  - A coin in the timeout cycle counts and can still produce success.
- PAY: lasts exactly 1 cycle. dispense=1, done=1, change = paid_money - require_money. Go to CHANGE.
- CHANGE: hold HOLD_S ticks. Then go to RETURN if done=1, otherwise go to ST.
- RETURN: hold HOLD_S ticks, then go to ST. Clear done, change, paid_money and money_enough.
- Hold counter: 4 bits, cleared on entry to every hold state, and counts only on tick_1hz. A state is held a minimum of HOLD_S-1 and a maximum of HOLD_S seconds.
- coin_valid outside TIME is ignored; these coins are rejected mechanically.
- Outputs are registered except money_enough. Values stay stable between transitions so the display can sample them at any time.

Optional Feature:
VEND_CTRL_EXTEND_EN
- Defined: every accepted coin in TIME that does not complete payment reloads left_time to TIMEOUT_S in the same edge.
- Undefined: coins never affect left_time.

Test Plan:
1. rst high 3 cycles mid-TIME with paid_money=4 -> state=001, paid_money=0, left_time=0, done=0 the cycle after the reset edge.
2. start, num=1,0,1,0, stock=9, confirm -> require_money=7, CHECK then TIME, left_time=30. Coins 5 then 5 -> PAY for 1 cycle with dispense=1, change=3, CHANGE for 5 ticks, RETURN for 5 ticks, then ST.
3. num1=4, stock1=3, confirm -> not_enough=1, CHECK held 5 ticks, then ST with not_enough=0. Same result with all nums=0.
4. require_money=9, coin 5, then 30 ticks -> CHANGE with change=5, done=0, then ST without entering RETURN. Coin 5 arriving on the final tick -> PAY, change=1.
5. In TIME with paid_money=3, cancel and coin_valid with coin_value=2 in the same cycle -> CHANGE with change=5. In SELECT, confirm and cancel together -> ST.
6. num=15,15,15,15 -> require_money saturates to 255. Coins totalling 300 -> paid_money=255, PAY, change=0. With VEND_CTRL_EXTEND_EN defined, a coin at left_time=3 -> left_time=30.
